// File: rtl/player_physics.sv
// Player movement: horizontal walk, jump arc under gravity, timed smash and landing recovery.
// All motion advances once per video frame on frame_tick.
module player_physics #(
   parameter int START_X      = 230,
   parameter int X_MIN        = 170,
   parameter int X_MAX        = 310,
   parameter int GROUND_Y     = 220,
   parameter int MOVE_SPEED   = 2,
   parameter int JUMP_V0      = 12,
   parameter int GRAVITY      = 1,
   parameter int SMASH_FRAMES = 8,
   parameter int LAND_FRAMES  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       jump,
   input  logic       smash,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [1:0] state,
   output logic       smash_active,
   output logic       jump_start
);

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      AIR    = 2'd1,
      SMASH  = 2'd2,
      LAND   = 2'd3
   } state_t;

   localparam logic [10:0] XMIN = 11'(X_MIN);
   localparam logic [10:0] XMAX = 11'(X_MAX);
   localparam logic [10:0] MV   = 11'(MOVE_SPEED);
   localparam logic [10:0] GY   = 11'(GROUND_Y);
   localparam logic [9:0]  SX   = 10'(START_X);
   localparam logic [9:0]  GY10 = 10'(GROUND_Y);
   localparam logic [5:0]  JV   = 6'(-JUMP_V0);
   localparam logic [6:0]  GR   = 7'(GRAVITY);
   localparam logic [7:0]  SLST = 8'(SMASH_FRAMES - 1);
   localparam logic [7:0]  LLST = 8'(LAND_FRAMES - 1);

   state_t             st;
   logic signed [5:0]  vy;
   logic [7:0]         cnt;

   logic [10:0]        px;
   logic [10:0]        xl;
   logic [10:0]        xr;
   logic [10:0]        nx;
   logic [10:0]        ny;
   logic signed [6:0]  vs;
   logic signed [5:0]  vy_n;
   logic               land;
   logic [9:0]         air_y;

   // Horizontal step, clamped to the court half without wrap-around.
   always_comb begin
      px = {1'b0, pos_x};
      xl = px - MV;
      xr = px + MV;
      nx = px;
      if (move_left && !move_right)
         nx = (px < XMIN + MV) ? XMIN : xl;
      else if (move_right && !move_left)
         nx = (xr > XMAX) ? XMAX : xr;
   end

   // Vertical step: 11-bit signed y, saturating 6-bit velocity.
   always_comb begin
      ny = {1'b0, pos_y} + {{5{vy[5]}}, vy};
      vs = {vy[5], vy} + GR;
      vy_n = vs[5:0];
      if (vs > 7'sd15)
         vy_n = 6'sd15;
      else if (vs < -7'sd16)
         vy_n = -6'sd16;
      land = !ny[10] && (ny >= GY);
      air_y = ny[9:0];
      if (land)
         air_y = GY10;
      else if (ny[10])
         air_y = 10'd0;
   end

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= GROUND;
         pos_x        <= SX;
         pos_y        <= GY10;
         vy           <= 6'sd0;
         cnt          <= 8'd0;
         smash_active <= 1'b0;
         jump_start   <= 1'b0;
      end else begin
         jump_start <= 1'b0;
         if (frame_tick) begin
            unique case (st)
               GROUND: begin
                  pos_x <= nx[9:0];
                  if (jump) begin
                     vy         <= JV;
                     st         <= AIR;
                     jump_start <= 1'b1;
                  end
               end
               AIR: begin
                  pos_x <= nx[9:0];
                  pos_y <= air_y;
                  vy    <= vy_n;
                  if (land) begin
                     vy  <= 6'sd0;
                     cnt <= 8'd0;
                     st  <= LAND;
                  end else if (smash) begin
                     cnt          <= 8'd0;
                     st           <= SMASH;
                     smash_active <= 1'b1;
                  end
               end
               SMASH: begin
                  pos_y <= air_y;
                  vy    <= vy_n;
                  if (land) begin
                     vy           <= 6'sd0;
                     cnt          <= 8'd0;
                     st           <= LAND;
                     smash_active <= 1'b0;
                  end else if (cnt == SLST) begin
                     st           <= AIR;
                     smash_active <= 1'b0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               LAND: begin
                  pos_x <= nx[9:0];
                  if (cnt == LLST) begin
                     cnt <= 8'd0;
                     st  <= GROUND;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               default: st <= GROUND;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_player_physics.sv
// Bench for player_physics: frame-level behavioural model compared every cycle,
// directed arc/smash/clamp scenarios with literal values, then random play.
module tb_player_physics;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       move_left = 1'b0;
   logic       move_right = 1'b0;
   logic       jump = 1'b0;
   logic       smash = 1'b0;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic [1:0] state;
   logic       smash_active;
   logic       jump_start;

   player_physics dut (
      .clk(clk),
      .rst_n(rst_n),
      .frame_tick(frame_tick),
      .move_left(move_left),
      .move_right(move_right),
      .jump(jump),
      .smash(smash),
      .pos_x(pos_x),
      .pos_y(pos_y),
      .state(state),
      .smash_active(smash_active),
      .jump_start(jump_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: position, velocity, mode and frames remaining in a timed mode.
   int m_x, m_y, m_vy, m_st, m_left;
   bit m_js;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_x = 230;
      m_y = 220;
      m_vy = 0;
      m_st = 0;
      m_left = 0;
      m_js = 0;
   endtask

   function automatic int sat(input int v);
      if (v > 15) return 15;
      if (v < -16) return -16;
      return v;
   endfunction

   task automatic model_tick();
      int ny;
      m_js = 0;
      if (!frame_tick) return;
      if (m_st != 2) begin
         if (move_left && !move_right)
            m_x = (m_x - 2 < 170) ? 170 : m_x - 2;
         else if (move_right && !move_left)
            m_x = (m_x + 2 > 310) ? 310 : m_x + 2;
      end
      case (m_st)
         0: if (jump) begin
            m_vy = -12;
            m_st = 1;
            m_js = 1;
         end
         1, 2: begin
            ny = m_y + m_vy;
            m_vy = sat(m_vy + 1);
            if (ny >= 220) begin
               m_y = 220;
               m_vy = 0;
               m_st = 3;
               m_left = 4;
            end else begin
               m_y = (ny < 0) ? 0 : ny;
               if (m_st == 1 && smash) begin
                  m_st = 2;
                  m_left = 8;
               end else if (m_st == 2) begin
                  m_left--;
                  if (m_left == 0) m_st = 1;
               end
            end
         end
         default: begin
            m_left--;
            if (m_left == 0) m_st = 0;
         end
      endcase
   endtask

   task automatic compare();
      chk("pos_x", 32'(pos_x), 32'(m_x));
      chk("pos_y", 32'(pos_y), 32'(m_y));
      chk("state", 32'(state), 32'(m_st));
      chk("smash_active", 32'(smash_active), 32'(m_st == 2));
      chk("jump_start", 32'(jump_start), 32'(m_js));
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge.
   task automatic step(input bit l, input bit r, input bit j, input bit s,
                       input bit t);
      move_left = l;
      move_right = r;
      jump = j;
      smash = s;
      frame_tick = t;
      @(posedge clk);
      model_tick();
      @(negedge clk);
      compare();
   endtask

   // A frame tick followed by an idle cycle with random (ignored) inputs.
   task automatic tick(input bit l, input bit r, input bit j, input bit s);
      step(l, r, j, s, 1'b1);
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare();
      @(negedge clk);
      compare();
      rst_n = 1'b1;
   endtask

   int x3, hi;

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare();
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
      chk("idle_x", 32'(pos_x), 230);
      chk("idle_y", 32'(pos_y), 220);
      chk("idle_state", 32'(state), 0);

      for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
      chk("right10_x", 32'(pos_x), 250);
      for (int i = 0; i < 50; i++) tick(0, 1, 0, 0);
      chk("right_clamp_x", 32'(pos_x), 310);
      for (int i = 0; i < 5; i++) tick(1, 1, 0, 0);
      chk("both_x", 32'(pos_x), 310);
      tick(0, 0, 0, 1);
      chk("ground_smash_state", 32'(state), 0);
      for (int i = 0; i < 80; i++) tick(1, 0, 0, 0);
      chk("left_clamp_x", 32'(pos_x), 170);
      for (int i = 0; i < 30; i++) tick(0, 1, 0, 0);
      chk("restore_x", 32'(pos_x), 230);

      // Full jump arc.
      step(0, 0, 1, 0, 1'b1);
      chk("jump_pulse", 32'(jump_start), 1);
      chk("jump_state", 32'(state), 1);
      step(0, 0, 0, 0, 1'b0);
      chk("jump_pulse_end", 32'(jump_start), 0);
      for (int k = 1; k <= 25; k++) begin
         tick(0, 0, 0, 0);
         if (k == 1) chk("air1_y", 32'(pos_y), 208);
         if (k == 12) chk("peak_y", 32'(pos_y), 142);
         if (k == 24) chk("air24_state", 32'(state), 1);
      end
      chk("land_y", 32'(pos_y), 220);
      chk("land_state", 32'(state), 3);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
      chk("land3_state", 32'(state), 3);
      tick(0, 0, 1, 0);
      chk("ground_state", 32'(state), 0);
      tick(0, 0, 1, 0);
      chk("held_jump_state", 32'(state), 1);
      for (int i = 0; i < 30; i++) tick(0, 0, 0, 0);
      chk("arc2_state", 32'(state), 0);

      // Smash in the air with move_right held.
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 1, 0, 1);
      x3 = 32'(pos_x);
      hi = 32'(smash_active);
      for (int k = 4; k <= 11; k++) begin
         tick(0, 1, 0, 1);
         hi += 32'(smash_active);
         if (k == 11) chk("smash_x_frozen", 32'(pos_x), 32'(x3));
      end
      chk("smash_exit_state", 32'(state), 1);
      for (int k = 12; k <= 14; k++) begin
         tick(0, 1, 0, 0);
         hi += 32'(smash_active);
         if (k == 12) chk("x_resume", 32'(pos_x), 32'(x3 + 2));
      end
      chk("smash_len", 32'(hi), 8);
      for (int i = 0; i < 30; i++) tick(0, 0, 0, 0);

      // Smash cut short by landing.
      tick(0, 0, 1, 0);
      for (int k = 1; k <= 19; k++) tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      for (int k = 21; k <= 25; k++) begin
         tick(0, 0, 0, 0);
         if (k == 24) chk("late_smash_state", 32'(state), 2);
      end
      chk("late_land_state", 32'(state), 3);
      chk("late_land_sa", 32'(smash_active), 0);
      for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

      // Reset in mid-arc.
      tick(0, 0, 1, 0);
      for (int k = 1; k <= 6; k++) tick(0, 0, 0, 0);
      async_reset();
      chk("rst_y", 32'(pos_y), 220);
      chk("rst_state", 32'(state), 0);
      for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);
      chk("post_rst_y", 32'(pos_y), 220);

      // Random play with occasional asynchronous resets.
      for (int i = 0; i < 6000; i++) begin
         step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 0));
         if ($urandom_range(0, 599) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/player_physics.md
PLAYER_PHYSICS -- requirements
Module: player_physics

Interface
REQ-001 The block SHALL have the following parameters:
- START_X, 230: reset horizontal position.
- X_MIN, 170: left limit, right of net.
- X_MAX, 310: right limit.
- GROUND_Y, 220: floor y; y grows downward.
- MOVE_SPEED, 2: pixels per frame.
- JUMP_V0, 12: initial upward speed.
- GRAVITY, 1: vy increment per frame.
- SMASH_FRAMES, 8: smash duration.
- LAND_FRAMES, 4: landing recovery.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- frame_tick, in, 1: one-cycle pulse per video frame.
- move_left, in, 1: level, from AI or keypad.
- move_right, in, 1: level.
- jump, in, 1: level.
- smash, in, 1: level.
- pos_x, out, 10: registered x; feeds controller my_pos_x.
- pos_y, out, 10: registered y; feeds controller my_pos_y.
- state, out, 2: 0 GROUND, 1 AIR, 2 SMASH, 3 LAND.
- smash_active, out, 1: high exactly while state is SMASH.
- jump_start, out, 1: one-cycle pulse on a GROUND->AIR transition.

Function
REQ-003 All state, position, velocity and counter updates SHALL occur only on clk edges where frame_tick=1; otherwise all registers SHALL hold.
REQ-004 Inputs SHALL be sampled on the tick edge, and the results SHALL be visible on the outputs from the next cycle (latency 1 clk).
REQ-005 Vertical velocity vy SHALL be signed 6-bit, saturating at +15 and -16.
REQ-006 Next y SHALL be computed as an 11-bit signed value, pos_y+vy.
REQ-007 Horizontal motion:
- move_left xor move_right moves pos_x by MOVE_SPEED in that direction.
- Both or neither asserted leaves pos_x unchanged.
- The result SHALL be clamped to [X_MIN, X_MAX], with no wrap-around.
REQ-008 Horizontal motion SHALL apply in GROUND, AIR and LAND, and SHALL be frozen in SMASH.
REQ-009 GROUND on a tick:
- If jump=1, set vy=-JUMP_V0, go to AIR, pulse jump_start, and leave pos_y unchanged this tick.
- smash in GROUND SHALL be ignored.
- jump and smash asserted together SHALL mean jump wins.
REQ-010 AIR on a tick:
- Compute ny = pos_y+vy and set vy = vy+GRAVITY.
- If ny >= GROUND_Y: pos_y=GROUND_Y, vy=0, land counter=0, go to LAND.
- Else if ny < 0: pos_y=0.
- Else: pos_y=ny.
REQ-011 AIR with smash=1 on a tick (and no landing on that tick) SHALL go to SMASH and clear the smash counter; vertical motion still applies on that tick.
REQ-012 SMASH on a tick:
- Vertical motion SHALL continue as in AIR, and the counter SHALL increment.
- When the counter reaches SMASH_FRAMES-1, go to AIR.
- Landing SHALL take priority: go to LAND immediately with smash_active cleared.
- smash held during SMASH SHALL NOT retrigger; re-entry needs a fresh AIR tick with smash=1.
REQ-013 LAND on a tick:
- The counter SHALL increment; jump SHALL be ignored.
- After LAND_FRAMES ticks, go to GROUND.
- A jump held through LAND SHALL jump on the first GROUND tick.
REQ-014 pos_y SHALL equal GROUND_Y in every GROUND and LAND cycle.

Reset
REQ-015 When rst_n=0, the block SHALL asynchronously set:
- pos_x=START_X, pos_y=GROUND_Y, vy=0.
- state=GROUND, smash_active=0, jump_start=0.
- All counters to 0.
REQ-016 Reset mid-air or mid-smash SHALL abort the motion with no residual velocity.
REQ-017 After release, the block SHALL begin updating on the first frame_tick.

Verification
REQ-018 Reset, then 3 ticks with no inputs -> pos=(230,220), state=0, all flags 0.
REQ-019 Clamp, overlap and GROUND smash:
- move_right held 10 ticks -> pos_x=250.
- Held 50 more ticks -> pos_x=310, never 312.
- move_left+move_right both held -> pos_x unchanged.
- smash on GROUND -> state stays 0.
REQ-020 Full jump arc:
- jump one tick -> jump_start one cycle, state=1.
- AIR tick 1 -> pos_y=208.
- AIR tick 12 -> pos_y=142 (peak).
- AIR tick 25 -> pos_y=220, state=3.
- 4 ticks later -> state=0.
REQ-021 Smash in air:
- Jump, then smash on AIR tick 3 with move_right held -> smash_active high for exactly 8 ticks.
- pos_x constant during those 8 ticks, then state=1 and x resumes.
REQ-022 Smash near landing: smash issued on AIR tick 20 -> landing at tick 25 forces state=3 with smash_active=0 before 8 ticks elapse.
REQ-023 Reset mid-arc: assert rst_n=0 at AIR tick 6 between clock edges -> outputs reset immediately; after release, 20 idle ticks -> pos_y stays 220.
